muldiv_iter: RTL and testbench
==============================

MULDIV_ITER -- requirements
Module: muldiv_iter

Interface
- REQ-001 SHALL have parameter WIDTH, default 32: operand width; results are 2*WIDTH; legal range 8-64, even values only.
- REQ-002 SHALL have parameter MUL_LATENCY, default 2: cycles from start to done for MUL/MADD/MSUB; minimum 1.
- REQ-003 SHALL have port clk, input, 1: single clock; all state on the rising edge.
- REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
- REQ-005 SHALL have port flush, input, 1: exception flush; aborts the operation in flight.
- REQ-006 SHALL have port start, input, 1: request an operation; accepted only while busy=0.
- REQ-007 SHALL have port op, input, 2: 00 MUL, 01 MADD, 10 MSUB, 11 DIV.
- REQ-008 SHALL have port flag_unsigned, input, 1: 1 = unsigned, 0 = two's-complement signed.
- REQ-009 SHALL have ports operand1 and operand2, input, WIDTH each: multiplicand/dividend and multiplier/divisor.
- REQ-010 SHALL have port hilo_i, input, 2*WIDTH: accumulator value for MADD/MSUB.
- REQ-011 SHALL have port busy, output, 1: an operation is in flight.
- REQ-012 SHALL have port done, output, 1: one-cycle pulse when result is valid.
- REQ-013 SHALL have port result, output, 2*WIDTH: product/accumulation result, or {remainder, quotient} for DIV.
- REQ-014 SHALL have port div0, output, 1: divide-by-zero flag, valid with done.

Function
- REQ-015 SHALL latch op, flag_unsigned, operand1, operand2 and hilo_i on the edge at which start=1 and busy=0 (edge 0); inputs after edge 0 are ignored.
- REQ-016 SHALL ignore start while busy=1.
- REQ-017 SHALL use states IDLE, MUL, DIV, FIX: IDLE->MUL or IDLE->DIV on accept; MUL->IDLE after MUL_LATENCY cycles; DIV->FIX after WIDTH iterations; FIX->IDLE after 1 cycle.
- REQ-018 SHALL assert busy in every state other than IDLE.
- REQ-019 SHALL, for MUL/MADD/MSUB, assert done during the cycle after edge MUL_LATENCY.
- REQ-020 SHALL, for DIV, run a radix-2 restoring iteration on absolute values, one quotient bit per cycle, and apply sign correction in FIX; done is asserted during the cycle after edge WIDTH+1.
- REQ-021 SHALL form MUL as the full 2*WIDTH product; MADD = hilo_i + product; MSUB = hilo_i - product; all arithmetic wraps mod 2^(2*WIDTH).
- REQ-022 SHALL, for signed DIV, truncate the quotient toward zero and give the remainder the dividend's sign.
- REQ-023 SHALL, for signed most-negative / -1, return quotient = most-negative value and remainder = 0.
- REQ-024 SHALL register result, update it only in the done cycle, and hold it until the next done.
- REQ-025 SHALL pulse done for exactly one cycle per accepted, unflushed operation; busy falls in the same cycle that done is high.
- REQ-026 SHALL, on flush=1, return to IDLE at the next edge with no done pulse, leaving result and div0 unchanged.
- REQ-027 SHALL give flush priority over start in the same cycle; that start is dropped.
- REQ-028 SHALL accept a new start in the cycle in which done is high.

Reset
- REQ-029 SHALL, while rst_n=0, force IDLE, busy=0, done=0, div0=0 and result=0, independent of clk.
- REQ-030 SHALL discard any operation in flight when reset is asserted mid-operation; no done follows reset release.

Configuration
- REQ-031 SHALL, with MULDIV_DIV0_FAST_EN defined, complete a DIV by zero at the first edge after acceptance: done during the cycle after edge 1, div0=1, quotient all-ones, remainder = dividend unchanged (the input value, not its absolute value).
- REQ-032 SHALL, without MULDIV_DIV0_FAST_EN, run a DIV by zero for the full WIDTH+1 latency with the same numeric result and div0 tied to 0.

Verification (WIDTH=32, MUL_LATENCY=2)
- REQ-033 Signed MUL -3 x 7 -> done in the cycle after edge 2, result 0xFFFFFFFF_FFFFFFEB.
- REQ-034 Unsigned MSUB, hilo_i 0x10, 3 x 4 -> result 0x00000000_00000004; a back-to-back start in the done cycle is accepted.
- REQ-035 Signed DIV -7 / 2 -> done in the cycle after edge 33, result 0xFFFFFFFF_FFFFFFFD (remainder -1, quotient -3).
- REQ-036 Signed DIV 0x80000000 / 0xFFFFFFFF -> result 0x00000000_80000000.
- REQ-037 Unsigned DIV 5 / 0 -> result 0x00000005_FFFFFFFF; with the macro: done after edge 1 and div0=1; without the macro: done after edge 33 and div0=0.
- REQ-038 DIV started, then flush at cycle 10 -> busy=0 next cycle, no done, result unchanged; the next start is accepted normally.

Source files
------------

// File: rtl/muldiv_iter.sv
// Iterative multiply / multiply-accumulate / restoring divide unit.
// Optional feature: define MULDIV_DIV0_FAST_EN to finish divide-by-zero one
// cycle after acceptance and report it on div0.
module muldiv_iter #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MUL_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic                 flag_unsigned,
  input  logic [WIDTH-1:0]     operand1,
  input  logic [WIDTH-1:0]     operand2,
  input  logic [2*WIDTH-1:0]   hilo_i,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 div0
);

  localparam int unsigned DW   = 2 * WIDTH;
  localparam int unsigned CMAX = (WIDTH > MUL_LATENCY) ? WIDTH : MUL_LATENCY;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MADD = 2'b01;
  localparam logic [1:0] OP_MSUB = 2'b10;
  localparam logic [1:0] OP_DIV  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_op;
  logic               r_uns;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [DW-1:0]      r_hilo;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_dvs;
  logic               r_qneg;
  logic               r_rneg;
  logic               r_dz;
  logic [CW-1:0]      r_cnt;

  logic               w_accept;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [DW-1:0]      w_ext_a;
  logic [DW-1:0]      w_ext_b;
  logic [DW-1:0]      w_prod;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic               w_fin;
  logic [DW-1:0]      w_res_nxt;
  logic               w_div0_nxt;

  assign w_accept = start & ~flush & (r_state == S_IDLE);

  // Operand magnitudes for the divider, sampled straight from the inputs at accept.
  assign w_neg_a = ~flag_unsigned & operand1[WIDTH-1];
  assign w_neg_b = ~flag_unsigned & operand2[WIDTH-1];
  assign w_abs_a = w_neg_a ? -operand1 : operand1;
  assign w_abs_b = w_neg_b ? -operand2 : operand2;

  // Full-width product from sign- or zero-extended latched operands.
  assign w_ext_a = r_uns ? {{WIDTH{1'b0}}, r_a} : {{WIDTH{r_a[WIDTH-1]}}, r_a};
  assign w_ext_b = r_uns ? {{WIDTH{1'b0}}, r_b} : {{WIDTH{r_b[WIDTH-1]}}, r_b};
  assign w_prod  = w_ext_a * w_ext_b;

  // One restoring step: shift in the next dividend bit and trial-subtract.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};

  assign w_quo_fix = r_qneg ? -r_quo : r_quo;
  assign w_rem_fix = r_rneg ? -r_rem : r_rem;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; flush returns to IDLE and drops any simultaneous start.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (start) w_state_nxt = (op == OP_DIV) ? S_DIV : S_MUL;
        S_MUL:  if (r_cnt == CW'(MUL_LATENCY)) w_state_nxt = S_IDLE;
        S_DIV: begin
`ifdef MULDIV_DIV0_FAST_EN
          if (r_dz) w_state_nxt = S_IDLE;
          else if (r_cnt == CW'(WIDTH - 1)) w_state_nxt = S_FIX;
`else
          if (r_cnt == CW'(WIDTH - 1)) w_state_nxt = S_FIX;
`endif
        end
        S_FIX:   w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output logic: decides when an operation completes and what it reports.
  always_comb begin
    w_fin      = 1'b0;
    w_res_nxt  = result;
    w_div0_nxt = div0;
    if (!flush) begin
      case (r_state)
        S_MUL: begin
          if (r_cnt == CW'(MUL_LATENCY)) begin
            w_fin      = 1'b1;
            w_div0_nxt = 1'b0;
            case (r_op)
              OP_MADD: w_res_nxt = r_hilo + w_prod;
              OP_MSUB: w_res_nxt = r_hilo - w_prod;
              default: w_res_nxt = w_prod;
            endcase
          end
        end
        S_DIV: begin
`ifdef MULDIV_DIV0_FAST_EN
          if (r_dz) begin
            w_fin      = 1'b1;
            w_div0_nxt = 1'b1;
            w_res_nxt  = {r_a, {WIDTH{1'b1}}};
          end
`endif
        end
        S_FIX: begin
          w_fin      = 1'b1;
          w_div0_nxt = 1'b0;
          w_res_nxt  = r_dz ? {r_a, {WIDTH{1'b1}}} : {w_rem_fix, w_quo_fix};
        end
        default: ;
      endcase
    end
  end

  // Registered status and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      div0   <= 1'b0;
      result <= '0;
    end else begin
      busy <= (w_state_nxt != S_IDLE);
      done <= w_fin;
      if (w_fin) begin
        result <= w_res_nxt;
        div0   <= w_div0_nxt;
      end
    end
  end

  // Operand capture, cycle counter and divider iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op   <= OP_MUL;
      r_uns  <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_hilo <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
      r_dz   <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_op   <= op;
      r_uns  <= flag_unsigned;
      r_a    <= operand1;
      r_b    <= operand2;
      r_hilo <= hilo_i;
      r_rem  <= '0;
      r_quo  <= w_abs_a;
      r_dvs  <= w_abs_b;
      r_qneg <= w_neg_a ^ w_neg_b;
      r_rneg <= w_neg_a;
      r_dz   <= (operand2 == '0);
      r_cnt  <= (op == OP_DIV) ? CW'(0) : CW'(1);
    end else if (r_state == S_MUL) begin
      r_cnt <= r_cnt + CW'(1);
    end else if (r_state == S_DIV) begin
      r_cnt <= r_cnt + CW'(1);
      if (!w_diff[WIDTH]) begin
        r_rem <= w_diff[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
      end else begin
        r_rem <= w_shift[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed self-checking bench for muldiv_iter (WIDTH=32, MUL_LATENCY=2).
module tb_muldiv_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic        uns = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [63:0] hilo = '0;
  logic        busy;
  logic        done;
  logic        div0;
  logic [63:0] result;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef MULDIV_DIV0_FAST_EN
  localparam int DZ_LAT  = 1;
  localparam bit DZ_FLAG = 1'b1;
`else
  localparam int DZ_LAT  = 33;
  localparam bit DZ_FLAG = 1'b0;
`endif

  muldiv_iter #(.WIDTH(32), .MUL_LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .start(start), .op(op),
    .flag_unsigned(uns), .operand1(a), .operand2(b), .hilo_i(hilo),
    .busy(busy), .done(done), .result(result), .div0(div0)
  );

  always #5 clk = ~clk;

  // Present one request for a single edge, then scramble the inputs.
  task automatic issue(input logic [1:0] o, input logic u, input logic [31:0] x,
                       input logic [31:0] y, input logic [63:0] h);
    @(negedge clk);
    start = 1'b1; op = o; uns = u; a = x; b = y; hilo = h;
    @(posedge clk);
    #1;
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    hilo = 64'h5555_AAAA_5555_AAAA; op = o ^ 2'b01; uns = ~u;
  endtask

  // Count edges after acceptance until done; -1 on timeout.
  task automatic wait_done(output int edges, output bit busy_ok);
    edges = -1;
    busy_ok = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        edges = i;
        if (busy !== 1'b0) busy_ok = 1'b0;
        break;
      end else if (busy !== 1'b1) begin
        busy_ok = 1'b0;
      end
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic u,
                        input logic [31:0] x, input logic [31:0] y, input logic [63:0] h,
                        input int exp_lat, input logic [63:0] exp_res, input logic exp_dz);
    int  edges;
    bit  bok;
    issue(o, u, x, y, h);
    wait_done(edges, bok);
    n_checks++;
    if (edges != exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d edges, expected %0d", name, edges, exp_lat);
    end
    n_checks++;
    if (result !== exp_res) begin
      n_fail++;
      $display("FAIL %s result: got %h, expected %h", name, result, exp_res);
    end
    n_checks++;
    if (div0 !== exp_dz || !bok) begin
      n_fail++;
      $display("FAIL %s div0/busy: div0=%b expected %b, busy_ok=%b expected 1", name, div0, exp_dz, bok);
    end
  endtask

  task automatic test_reset;
    #2;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || div0 !== 1'b0 || result !== 64'h0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b div0=%b result=%h, expected all zero", busy, done, div0, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul;
    run_op("mul_signed", 2'b00, 1'b0, 32'hFFFF_FFFD, 32'd7, 64'h0, 2, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: done=%b one cycle later, expected 0", done);
    end
    run_op("madd_unsigned", 2'b01, 1'b1, 32'd3, 32'd4, 64'h10, 2, 64'h1C, 1'b0);
    run_op("madd_signed", 2'b01, 1'b0, 32'hFFFF_FFFE, 32'd3, 64'h100, 2, 64'hFA, 1'b0);
    run_op("msub_signed", 2'b10, 1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 64'h0, 2, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_op("msub_unsigned", 2'b10, 1'b1, 32'd3, 32'd4, 64'h10, 2, 64'h4, 1'b0);
    // still inside the done cycle: next request goes in at the following edge
    run_op("b2b_mul", 2'b00, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0, 2, 64'hFFFF_FFFE_0000_0001, 1'b0);
  endtask

  task automatic test_ignore_start;
    int  edges;
    bit  bok;
    int  extra;
    issue(2'b00, 1'b1, 32'd6, 32'd7, 64'h0);
    @(negedge clk);
    start = 1'b1; op = 2'b00; uns = 1'b1; a = 32'd100; b = 32'd100;
    wait_done(edges, bok);
    start = 1'b0;
    n_checks++;
    if (edges != 2 || result !== 64'd42) begin
      n_fail++;
      $display("FAIL ignore_start: edges=%0d result=%h, expected 2 and %h", edges, result, 64'd42);
    end
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL ignore_start_extra_done: got %0d extra done pulses, expected 0", extra);
    end
  endtask

  task automatic test_div;
    run_op("div_neg7_2", 2'b11, 1'b0, 32'hFFFF_FFF9, 32'd2, 64'h0, 33, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    run_op("div_minneg", 2'b11, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0, 33, 64'h0000_0000_8000_0000, 1'b0);
    run_op("div_unsigned", 2'b11, 1'b1, 32'd100, 32'd7, 64'h0, 33, {32'd2, 32'd14}, 1'b0);
    run_op("div_7_neg2", 2'b11, 1'b0, 32'd7, 32'hFFFF_FFFE, 64'h0, 33, 64'h0000_0001_FFFF_FFFD, 1'b0);
    run_op("div_big_unsigned", 2'b11, 1'b1, 32'hFFFF_FFFF, 32'h0001_0000, 64'h0, 33, 64'h0000_FFFF_0000_FFFF, 1'b0);
  endtask

  task automatic test_div0;
    run_op("div0_unsigned", 2'b11, 1'b1, 32'd5, 32'd0, 64'h0, DZ_LAT, 64'h0000_0005_FFFF_FFFF, DZ_FLAG);
    run_op("div0_signed", 2'b11, 1'b0, 32'hFFFF_FFFB, 32'd0, 64'h0, DZ_LAT, 64'hFFFF_FFFB_FFFF_FFFF, DZ_FLAG);
  endtask

  task automatic test_flush;
    int  seen;
    // last completed result before this test: signed -5/0
    logic [63:0] prev = 64'hFFFF_FFFB_FFFF_FFFF;
    issue(2'b11, 1'b1, 32'd1000, 32'd3, 64'h0);
    seen = 0;
    for (int i = 1; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen++;
    end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle: busy=%b done=%b, expected 0 0", busy, done);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0 || result !== prev) begin
      n_fail++;
      $display("FAIL flush_no_done: done pulses=%0d result=%h, expected 0 and %h", seen, result, prev);
    end
    // flush beats start in the same cycle
    @(negedge clk);
    flush = 1'b1; start = 1'b1; op = 2'b00; uns = 1'b1; a = 32'd2; b = 32'd2;
    @(posedge clk);
    #1;
    flush = 1'b0; start = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_over_start: busy=%b, expected 0", busy);
    end
    run_op("after_flush", 2'b00, 1'b1, 32'd9, 32'd9, 64'h0, 2, 64'd81, 1'b0);
  endtask

  task automatic test_reset_mid;
    int seen;
    issue(2'b11, 1'b1, 32'd50, 32'd5, 64'h0);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || div0 !== 1'b0 || result !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b div0=%b result=%h, expected all zero", busy, done, div0, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL reset_discard: %0d cycles with busy/done after reset, expected 0", seen);
    end
    run_op("after_reset", 2'b11, 1'b0, 32'hFFFF_FF9C, 32'd10, 64'h0, 33, 64'h0000_0000_FFFF_FFF6, 1'b0);
  endtask

  initial begin
    test_reset;
    test_mul;
    test_back_to_back;
    test_ignore_start;
    test_div;
    test_div0;
    test_flush;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
